// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    // Base bit of port 'port' in a packed bus of 'width'-bit lanes.
    function automatic int rf_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, then raises Ready and
// stays in RUN until the next reset.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_idx_o
);

    // state    | meaning
    // RF_CLEAR | zeroing entry idx_q each cycle, user writes dropped
    // RF_RUN   | normal operation, Ready high
    rf_state_e         state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= RF_RUN;
                        ready_q <= 1'b1;
                    end
                end
                RF_RUN: begin
                    state_q <= RF_RUN;
                end
                default: begin
                    state_q <= RF_CLEAR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we_o  = (state_q == RF_CLEAR) && !rst_i;
    assign clr_idx_o = idx_q;
    assign ready_o   = ready_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised N-read / 1-write register file with hardwired zero register and
// post-reset clear. Define REGFILE_BYPASS_EN for same-cycle write-through reads.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [NUM_READ*$clog2(DEPTH)-1:0] Read_Register,
    output logic [NUM_READ*DATA_W-1:0]        Read_Data,
    input  logic [$clog2(DEPTH)-1:0]          Write_Register,
    input  logic [DATA_W-1:0]                 Write_Data,
    input  logic                              Sig_Reg_Write,
    output logic                              Ready,
    output logic                              Sig_Write_Drop
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              zero_hit;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_val;

    regfile_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .ready_o   (Ready),
        .clr_we_o  (clr_we),
        .clr_idx_o (clr_idx)
    );

    assign zero_hit       = (ZERO_REG != 0) && (Write_Register == '0);
    assign wr_en          = Sig_Reg_Write && Ready && !zero_hit;
    assign Sig_Write_Drop = Sig_Reg_Write && (!Ready || zero_hit);

    always_ff @(posedge Clk) begin
        if (clr_we) begin
            mem_q[clr_idx] <= '0;
        end else if (wr_en) begin
            mem_q[Write_Register] <= Write_Data;
        end
    end

    // Zero forcing is applied last so it overrides any forwarded value.
    always_comb begin
        Read_Data = '0;
        rd_idx    = '0;
        rd_val    = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            rd_idx = Read_Register[rf_slice(k, ADDR_W) +: ADDR_W];
            rd_val = mem_q[rd_idx];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (rd_idx == Write_Register)) begin
                rd_val = Write_Data;
            end
`endif
            if (!Ready || ((ZERO_REG != 0) && (rd_idx == '0))) begin
                rd_val = '0;
            end
            Read_Data[rf_slice(k, DATA_W) +: DATA_W] = rd_val;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: two configurations (32x32/2R and 16x64/4R) checked against
// an array-based reference model.
module tb_regfile_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst, a_we, a_rdy, a_drop;
    logic [9:0]   a_rr;
    logic [63:0]  a_rd;
    logic [4:0]   a_wr;
    logic [31:0]  a_wd;

    logic         b_rst, b_we, b_rdy, b_drop;
    logic [15:0]  b_rr;
    logic [255:0] b_rd;
    logic [3:0]   b_wr;
    logic [63:0]  b_wd;

    regfile_multiport #(.DATA_W(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1)) dut_a (
        .Clk(clk), .Reset(a_rst), .Read_Register(a_rr), .Read_Data(a_rd),
        .Write_Register(a_wr), .Write_Data(a_wd), .Sig_Reg_Write(a_we),
        .Ready(a_rdy), .Sig_Write_Drop(a_drop)
    );

    regfile_multiport #(.DATA_W(64), .DEPTH(16), .NUM_READ(4), .ZERO_REG(1)) dut_b (
        .Clk(clk), .Reset(b_rst), .Read_Register(b_rr), .Read_Data(b_rd),
        .Write_Register(b_wr), .Write_Data(b_wd), .Sig_Reg_Write(b_we),
        .Ready(b_rdy), .Sig_Write_Drop(b_drop)
    );

    // Reference model: contents, ready flag, edges since reset release.
    logic [31:0] a_mem [32];
    logic [63:0] b_mem [16];
    bit          a_ready, b_ready;
    int          a_cnt, b_cnt;

    typedef struct {
        int          inst;
        int          port;
        logic [63:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_err   = 0;

    function automatic logic [31:0] a_model_rd(input int idx);
        if (!a_ready || idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (a_we && int'(a_wr) == idx) return a_wd;
`endif
        return a_mem[idx];
    endfunction

    function automatic logic [63:0] b_model_rd(input int idx);
        if (!b_ready || idx == 0) return 64'h0;
`ifdef REGFILE_BYPASS_EN
        if (b_we && int'(b_wr) == idx) return b_wd;
`endif
        return b_mem[idx];
    endfunction

    function automatic logic [63:0] actual(input int inst, input int port);
        if (inst == 0) begin
            if (port == -1) return {63'h0, a_rdy};
            if (port == -2) return {63'h0, a_drop};
            return {32'h0, a_rd[port*32 +: 32]};
        end
        if (port == -1) return {63'h0, b_rdy};
        if (port == -2) return {63'h0, b_drop};
        return b_rd[port*64 +: 64];
    endfunction

    task automatic push(input int inst, input int port, input logic [63:0] exp);
        chk_t c;
        c.inst = inst;
        c.port = port;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic check_a();
        push(0, -1, {63'h0, a_ready});
        push(0, -2, {63'h0, a_we && (!a_ready || a_wr == 5'd0)});
        for (int k = 0; k < 2; k++) push(0, k, {32'h0, a_model_rd(int'(a_rr[k*5 +: 5]))});
    endtask

    task automatic check_b();
        push(1, -1, {63'h0, b_ready});
        push(1, -2, {63'h0, b_we && (!b_ready || b_wr == 4'd0)});
        for (int k = 0; k < 4; k++) push(1, k, b_model_rd(int'(b_rr[k*4 +: 4])));
    endtask

    // Apply the effect of the current inputs at the coming edge, then advance.
    task automatic step();
        if (a_rst) begin
            a_cnt = 0; a_ready = 0;
            for (int i = 0; i < 32; i++) a_mem[i] = '0;
        end else if (!a_ready) begin
            a_cnt++;
            if (a_cnt == 32) a_ready = 1;
        end else if (a_we && a_wr != 5'd0) begin
            a_mem[a_wr] = a_wd;
        end
        if (b_rst) begin
            b_cnt = 0; b_ready = 0;
            for (int i = 0; i < 16; i++) b_mem[i] = '0;
        end else if (!b_ready) begin
            b_cnt++;
            if (b_cnt == 16) b_ready = 1;
        end else if (b_we && b_wr != 4'd0) begin
            b_mem[b_wr] = b_wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        check_a();
        check_b();
        step();
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t        it;
            logic [63:0] act;
            it  = q.pop_front();
            act = actual(it.inst, it.port);
            n_total++;
            if (act === it.exp) n_pass++;
            else $display("FAIL inst%0d port%0d: got %h expected %h at %0t",
                          it.inst, it.port, act, it.exp, $time);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish at %0t", $time);
        $finish;
    end

    initial begin
        a_rst = 1; a_we = 0; a_wr = '0; a_wd = '0; a_rr = '0;
        b_rst = 1; b_we = 0; b_wr = '0; b_wd = '0; b_rr = '0;
        a_ready = 0; b_ready = 0; a_cnt = 0; b_cnt = 0;
        #1;
        step();
        if (a_rdy !== 1'b0 || b_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL reset state: Ready a=%b b=%b expected 0 at %0t", a_rdy, b_rdy, $time);
        end
        cyc();                                   // reset state, still in reset

        // Clear sweep; write to reg 5 attempted on clear edge 10.
        a_rst = 0; b_rst = 0;
        for (int e = 0; e < 32; e++) begin
            a_rr = {5'((e + 16) % 32), 5'(e)};
            b_rr = 16'($urandom);
            a_we = (e == 9); a_wr = 5'd5; a_wd = 32'h55;
            b_we = (e == 3); b_wr = 4'd2; b_wd = {$urandom, $urandom};
            cyc();
        end
        a_we = 0; b_we = 0;
        if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL clear wait expired: Ready a=%b b=%b expected 1 at %0t", a_rdy, b_rdy, $time);
        end

        a_we = 1; a_wr = 5'd3; a_wd = 32'd20; cyc();
        a_we = 0; a_rr = {5'd4, 5'd3}; cyc();
        a_we = 1; a_wr = 5'd0; a_wd = 32'd10; a_rr = {5'd3, 5'd0}; cyc();
        a_we = 0; cyc();
        a_rr = {5'd5, 5'd5}; cyc();

        a_we = 1; a_wr = 5'd7; a_wd = 32'h1; cyc();
        a_wd = 32'hDEADBEEF; a_rr = {5'd7, 5'd7}; cyc();
        a_we = 0; cyc();

        for (int i = 1; i < 16; i++) begin
            b_we = 1; b_wr = 4'(i); b_wd = {$urandom, $urandom};
            b_rr = 16'($urandom);
            cyc();
        end
        b_we = 0; b_rr = {4'd12, 4'd7, 4'd1, 4'd15}; cyc();

        for (int n = 0; n < 300; n++) begin
            a_we = 1'($urandom_range(0, 1)); a_wr = 5'($urandom); a_wd = $urandom;
            a_rr = 10'($urandom);
            if ($urandom_range(0, 3) == 0) a_rr[4:0] = a_wr;
            b_we = 1'($urandom_range(0, 1)); b_wr = 4'($urandom); b_wd = {$urandom, $urandom};
            b_rr = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b_rr[7:4] = b_wr;
            cyc();
        end
        a_we = 0; b_we = 0;

        // Reset, abort the clear at index 17, then a full clear.
        a_rst = 1; b_rst = 1; cyc();
        a_rst = 0; b_rst = 0;
        for (int e = 0; e < 17; e++) begin
            a_rr = 10'($urandom); b_rr = 16'($urandom); cyc();
        end
        a_rst = 1; b_rst = 1; cyc();
        a_rst = 0; b_rst = 0;
        for (int e = 0; e < 64; e++) begin
            a_rr = {5'((e + 16) % 32), 5'(e % 32)};
            b_rr = {4'(e + 3), 4'(e + 2), 4'(e + 1), 4'(e)};
            if (e == 31 && a_rdy !== 1'b0) begin
                n_err++;
                $display("FAIL early Ready after restart at %0t", $time);
            end
            cyc();
            if (e == 31 && a_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL restart wait expired: Ready=%b expected 1 at %0t", a_rdy, $time);
            end
        end

        @(negedge clk);
        #1;
        if (n_pass != n_total || n_err != 0)
            $display("FAIL summary: %0d/%0d scoreboard checks passed, %0d direct failures",
                     n_pass, n_total, n_err);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the processor's two-read/one-write register file.
- Configurable data width, depth and read-port count; clocked write port; hardwired zero register.
- Built-in clear engine zeroes every entry after reset, one entry per cycle, and signals readiness to the pipeline.
- Sits in the decode stage; read ports feed the ALU operand muxes, and the write port is driven by writeback.

Parameters:
- DATA_W, 32, width of each register in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register index width; derived, not overridden.
- NUM_READ, 2, number of independent read ports, 1..8.
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Read_Register  in  NUM_READ*ADDR_W  packed read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
- Read_Data  out  NUM_READ*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
- Write_Register  in  ADDR_W  write index.
- Write_Data  in  DATA_W  write data.
- Sig_Reg_Write  in  1  write enable.
- Ready  out  1  high when the file is in RUN and accepts writes.
- Sig_Write_Drop  out  1  combinational; high when Sig_Reg_Write=1 and Ready=0, or when a write targets register 0 with ZERO_REG=1.

Behaviour:
- Reset is synchronous, active-high, on Clk.
  - Any edge with Reset=1: state<=CLEAR, Clear_Idx<=0, Ready<=0.
  - Array contents are not reset directly; the clear engine zeroes them.
- FSM has two states, CLEAR and RUN.
  - CLEAR, Reset=0: write 0 to entry Clear_Idx, then Clear_Idx<=Clear_Idx+1. When Clear_Idx==DEPTH-1, state<=RUN and Ready<=1 on that edge.
  - The clear therefore takes exactly DEPTH edges after Reset deasserts; Ready rises on edge DEPTH.
  - RUN: stays in RUN until Reset.
- Reset asserted mid-clear restarts the clear from index 0. Reset in RUN re-enters CLEAR.
- Writes:
  - In RUN, with Sig_Reg_Write=1 and not (ZERO_REG and Write_Register==0): mem[Write_Register]<=Write_Data on the rising edge.
  - In CLEAR, user writes are ignored, never queued, and Sig_Write_Drop=1.
- Reads:
  - Combinational with zero latency: Read_Data[k] = mem[Read_Register[k]].
  - Forced to 0 while state==CLEAR.
  - Forced to 0 when ZERO_REG=1 and the index is 0.
  - All ports are independent; the same index on several ports returns the same value.
- Read and write to the same index in the same cycle: the read returns the old value (new value visible after the edge), unless the optional feature below is enabled.
- Registered outputs (Ready) are 0 during and after reset until the clear completes. Read_Data is 0 throughout CLEAR.
- No X propagation: every entry is defined after the clear.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If state==RUN, Sig_Reg_Write=1, the write is not dropped, and Read_Register[k]==Write_Register, then Read_Data[k]=Write_Data in the same cycle. Zero-register forcing still takes priority.
- Undefined: no forwarding; a same-cycle read returns the pre-write contents. The writeback stage then relies on the pipeline's hazard stall.

Decomposition:
- Package regfile_pkg holds:
  - state enum RF_CLEAR/RF_RUN;
  - default constants RF_DATA_W=32, RF_DEPTH=32;
  - function rf_slice for packed-port indexing.
- One natural sub-module, regfile_clear_ctrl: the FSM plus Clear_Idx counter, producing Ready, clear-write enable and clear index.
- Storage array and read muxes stay in the top.

Test Plan:
- Reset for 1 cycle, then release, with DEPTH=32 → Ready=0 for 32 edges, 1 on edge 32; every port reads 0 for indices 0..31.
- After Ready: write 20 to reg 3, then read ports 0/1 = 3/4 → 20 / 0.
- Write 10 to reg 0 with ZERO_REG=1 → Sig_Write_Drop=1; a read of reg 0 returns 0. Read of reg 3 still returns 20.
- Sig_Reg_Write=1 for reg 5 on edge 10 of the clear → Sig_Write_Drop=1; reg 5 reads 0 after Ready.
  - Then assert Reset at clear index 17 → Ready rises 32 edges after the second deassertion.
- Same-cycle write 0xDEADBEEF and read of reg 7 (previously 0x1):
  - without REGFILE_BYPASS_EN → 0x1, then 0xDEADBEEF next cycle;
  - with it → 0xDEADBEEF immediately.
- NUM_READ=4, DATA_W=64, DEPTH=16: write distinct values to regs 1..15, read four distinct indices per cycle → every port matches the reference model. Write to index 15 then reading index 15 confirms the top index is reachable.
